ram_block_tdp: RTL and testbench
================================

# ram_block_tdp

Parametrised true-dual-port block RAM with per-lane byte write enables, selectable read latency, read-valid strobes and a hardware clear sequencer. It is the next-generation on-chip memory primitive for instruction/data caches, tag/state arrays and the bootloader region. It replaces the fixed-width dual-port arrays and their simulation-only zero initialisation with a clear that is synthesisable and can be re-triggered at runtime.

## Interface
- ADDR_WIDTH, 15, address bits; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width
- LANE_WIDTH, 8, byte-enable granularity; DATA_WIDTH % LANE_WIDTH == 0; NL = DATA_WIDTH/LANE_WIDTH
- READ_LATENCY, 1, 1 or 2 cycles from accepted read to rdata
- CLEAR_ON_RESET, 1, run clear sweep after reset release
- CLEAR_VALUE, '0, DATA_WIDTH word written by the sweep
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- clear  in  1  one-cycle pulse: start clear sweep
- ready  out  1  high when ports accept requests
- collision  out  1  sticky same-address write-write flag
- enN  in  1  port N request (N = 0, 1)
- weN  in  NL  port N lane write enables; all-zero means read
- addrN  in  ADDR_WIDTH  port N address
- wdataN  in  DATA_WIDTH  port N write data
- rdataN  out  DATA_WIDTH  port N read data
- rvalidN  out  1  rdataN valid strobe

## Operation
- Request accepted when enN && ready. Every accepted request, including writes, returns the old word (read-first) on rdataN and pulses rvalidN.
- Write: lanes with weN[i]=1 are updated; other lanes keep their contents.
- Same-address cross-port in the same cycle:
  - write/write: port 0 wins per lane; port 1's overlapping lanes are suppressed.
  - read/write: the reader sees the old word (read-first on both ports).
- Clear FSM states IDLE, SWEEP, DONE:
  - After reset: SWEEP if CLEAR_ON_RESET, otherwise IDLE.
  - IDLE -> SWEEP on clear.
  - SWEEP writes CLEAR_VALUE (all lanes) at counter address through port 0, one address per cycle, counter from 0.
  - SWEEP -> DONE at address 2**ADDR_WIDTH-1. DONE -> IDLE after one cycle.
- ready = (state == IDLE).
- Requests with enN high while not ready are dropped: no write, no rvalid. clear during SWEEP/DONE is ignored.
- Reset does not alter array contents. Reset during SWEEP aborts it; if CLEAR_ON_RESET, the sweep restarts from address 0 after release.

## Timing
- Reset values: rdataN = 0, rvalidN = 0, ready = 0 while rstn is low, collision = 0, FSM state/counter = 0.
- READ_LATENCY=1: rdata/rvalid in the cycle after acceptance.
- READ_LATENCY=2: an extra output register stage. rvalid is pipelined identically; rdata holds its last value when rvalid=0.
- The write takes effect at the accepting edge. A read of the same address in the next cycle returns the new data.
- Sweep duration is exactly 2**ADDR_WIDTH cycles in SWEEP plus 1 in DONE. ready rises in the cycle after DONE.
- No back-pressure: the block accepts a request every cycle on both ports.

## Configuration
- RAM_BLOCK_COLLISION_DETECT_EN defined:
  - collision is set on the edge where both ports are accepted with the same address and overlapping lane enables.
  - It is cleared only by rstn or by clear.
  - Simulation also emits $error on the event.
- Undefined: collision is tied to 0 and no detection logic is built. Port-0 priority still applies.

## Structure
- Package ram_block_pkg:
  - clear_state_e enum (IDLE, SWEEP, DONE)
  - READ_LATENCY legality check function
  - lane-mask merge function (old, new, we) -> word
- Sub-module ram_block_clear_fsm:
  - owns the state and address counter
  - outputs ready, sweep_we, sweep_addr
  - the top muxes these onto port 0
- Memory array is inferred with the block ram_style attribute. The two port always_ff blocks stay separate so the array maps to TDP BRAM.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5:
  - ready rises exactly 17 cycles after rstn release.
  - Reading all 16 addresses returns 32'hA5A5A5A5.
- Port 0 writes 32'h11223344 @5 with we=4'b0101, old word 32'hA5A5A5A5; then reads @5:
  - rdata = 32'hA522A544.
  - The write cycle itself returns 32'hA5A5A5A5 with rvalid.
- Same cycle: port 0 writes 32'hDEADBEEF @3 (we=4'hF), port 1 writes 32'h0 @3 (we=4'hF):
  - @3 = 32'hDEADBEEF.
  - collision = 1 with the macro, 0 without.
- READ_LATENCY=2, back-to-back reads @1, @2 on port 1:
  - rvalid1 high in cycles +2 and +3 with the matching data.
- Pulse clear mid-traffic:
  - ready drops in the next cycle.
  - Concurrent en0/en1 requests produce no rvalid and no writes.
  - After the sweep, all addresses hold CLEAR_VALUE.
- Assert rstn low at sweep address 7, then release:
  - Outputs return to reset values.
  - The sweep restarts at address 0 and finishes a full 2**ADDR_WIDTH-cycle pass.

Source files
------------

// File: rtl/ram_block_pkg.sv
// Shared types and helpers for the true-dual-port block RAM and its clear sequencer.
package ram_block_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clear_state_e;

  localparam int MAX_DW = 1024;
  localparam int MAX_NL = 128;

  function automatic bit rl_legal(input int rl);
    return (rl == 1) || (rl == 2);
  endfunction

  // Lane-granular merge: lanes with we set take new_w, the rest keep old_w.
  function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_NL-1:0] we,
                                                   input int lane_w);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int b = 0; b < MAX_DW; b++)
      if ((b / lane_w) < MAX_NL && we[b / lane_w]) r[b] = new_w[b];
    return r;
  endfunction

endpackage

// File: rtl/ram_block_tdp_if.sv
// Request/response bundle for both RAM ports plus the clear/ready/collision sideband.
interface ram_block_tdp_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int NL         = 4
);
  logic                  clear, ready, collision;
  logic                  en0, en1;
  logic [NL-1:0]         we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  rvalid0, rvalid1;

  modport master (
    output clear, en0, en1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ready, collision, rdata0, rdata1, rvalid0, rvalid1
  );

  modport slave (
    input  clear, en0, en1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ready, collision, rdata0, rdata1, rvalid0, rvalid1
  );
endinterface

// File: rtl/ram_block_clear_fsm.sv
// Clear sequencer: sweeps every address once through port 0, then re-opens the ports.
module ram_block_clear_fsm
  import ram_block_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  output logic                  ready,
  output logic                  sweep_we,
  output logic [ADDR_WIDTH-1:0] sweep_addr
);

  localparam clear_state_e RST_STATE = CLEAR_ON_RESET ? SWEEP : IDLE;

  clear_state_e          state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (clear) begin
        state_nx = SWEEP;
        cnt_nx   = '0;
      end
      SWEEP: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == '1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gated with rstn so the ports read as closed for the whole reset window.
  assign ready      = (state == IDLE) && rstn;
  assign sweep_we   = (state == SWEEP);
  assign sweep_addr = cnt;

endmodule

// File: rtl/ram_block_tdp.sv
// True-dual-port block RAM: lane write enables, read-first, 1/2-cycle read latency, clear sweep.
// Optional: RAM_BLOCK_COLLISION_DETECT_EN builds the sticky same-address write-write flag.
module ram_block_tdp
  import ram_block_pkg::*;
#(
  parameter int                      ADDR_WIDTH     = 15,
  parameter int                      DATA_WIDTH     = 32,
  parameter int                      LANE_WIDTH     = 8,
  parameter int                      READ_LATENCY   = 1,
  parameter bit                      CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE    = '0
) (
  input logic             clk,
  input logic             rstn,
  ram_block_tdp_if.slave  bus
);

  localparam int NL    = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int RL    = rl_legal(READ_LATENCY) ? READ_LATENCY : 1;

  logic                  ready, sweep_we, same_addr;
  logic [ADDR_WIDTH-1:0] sweep_addr, a0;
  logic [DATA_WIDTH-1:0] wd0, rd0_q, rd1_q;
  logic [NL-1:0]         we0_eff, we1_eff;
  logic                  acc0, acc1;
  logic [RL:0]           vld0_pipe, vld1_pipe;

  ram_block_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_clr (
    .clk, .rstn, .clear(bus.clear), .ready, .sweep_we, .sweep_addr
  );

  assign bus.ready = ready;
  assign acc0      = bus.en0 & ready;
  assign acc1      = bus.en1 & ready;
  assign same_addr = acc0 & acc1 & (bus.addr0 == bus.addr1);

  // The sweep owns port 0 while active; ready is low then, so no user request competes.
  assign a0      = sweep_we ? sweep_addr : bus.addr0;
  assign wd0     = sweep_we ? CLEAR_VALUE : bus.wdata0;
  assign we0_eff = sweep_we ? '1 : (acc0 ? bus.we0 : '0);
  assign we1_eff = acc1 ? (bus.we1 & ~(same_addr ? bus.we0 : '0)) : '0;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin : p0_wr
    for (int i = 0; i < NL; i++)
      if (we0_eff[i]) mem[a0][i*LANE_WIDTH +: LANE_WIDTH] <= wd0[i*LANE_WIDTH +: LANE_WIDTH];
  end

  always_ff @(posedge clk) begin : p1_wr
    for (int i = 0; i < NL; i++)
      if (we1_eff[i]) mem[bus.addr1][i*LANE_WIDTH +: LANE_WIDTH] <= bus.wdata1[i*LANE_WIDTH +: LANE_WIDTH];
  end

  always_ff @(posedge clk or negedge rstn) begin : p0_rd
    if (!rstn)     rd0_q <= '0;
    else if (acc0) rd0_q <= mem[bus.addr0];
  end

  always_ff @(posedge clk or negedge rstn) begin : p1_rd
    if (!rstn)     rd1_q <= '0;
    else if (acc1) rd1_q <= mem[bus.addr1];
  end

  assign vld0_pipe[0] = acc0;
  assign vld1_pipe[0] = acc1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld0_pipe[RL:1] <= '0;
      vld1_pipe[RL:1] <= '0;
    end else begin
      vld0_pipe[RL:1] <= vld0_pipe[RL-1:0];
      vld1_pipe[RL:1] <= vld1_pipe[RL-1:0];
    end
  end

  generate
    if (RL == 2) begin : g_rl2
      logic [DATA_WIDTH-1:0] rd0_o, rd1_o;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rd0_o <= '0;
          rd1_o <= '0;
        end else begin
          if (vld0_pipe[1]) rd0_o <= rd0_q;
          if (vld1_pipe[1]) rd1_o <= rd1_q;
        end
      end
      assign bus.rdata0 = rd0_o;
      assign bus.rdata1 = rd1_o;
    end else begin : g_rl1
      assign bus.rdata0 = rd0_q;
      assign bus.rdata1 = rd1_q;
    end
  endgenerate

  assign bus.rvalid0 = vld0_pipe[RL];
  assign bus.rvalid1 = vld1_pipe[RL];

`ifdef RAM_BLOCK_COLLISION_DETECT_EN
  logic col_q, col_hit;
  assign col_hit = same_addr & (|(bus.we0 & bus.we1));

  // An accepted clear wins over a collision in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   col_q <= 1'b0;
    else if (bus.clear && ready) col_q <= 1'b0;
    else if (col_hit)            col_q <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn && col_hit) $error("ram_block_tdp: write-write collision at addr %0h", bus.addr0);
  end
`endif
  assign bus.collision = col_q;
`else
  assign bus.collision = 1'b0;
`endif

endmodule

// File: tb/tb_ram_block_tdp.sv
// Scoreboard bench: two DUTs (read latency 1 and 2) share random stimulus against an array model.
module tb_ram_block_tdp;
  localparam int AW = 4, DW = 32, NL = 4, DEPTH = 16;
  localparam logic [DW-1:0] CV = 32'hA5A5A5A5;
`ifdef RAM_BLOCK_COLLISION_DETECT_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  typedef struct packed { logic [DW-1:0] data; logic [31:0] cyc; } sb_t;
  typedef struct packed { bit en; logic [NL-1:0] we; logic [AW-1:0] addr; logic [DW-1:0] wd; } req_t;

  logic clk = 1'b0, rstn = 1'b0, clear = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic [NL-1:0] we0 = '0, we1 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;

  int total = 0, bad = 0;
  logic [31:0] cyc = 0;
  logic [DW-1:0] mdl [DEPTH];
  logic [31:0] busy_from = 0, rdy_at = 0;
  bit col_exp = 1'b0;
  sb_t expq [4][$];

  ram_block_tdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NL(NL)) if_a ();
  ram_block_tdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NL(NL)) if_b ();

  assign if_a.clear = clear;   assign if_b.clear = clear;
  assign if_a.en0 = en0;       assign if_b.en0 = en0;
  assign if_a.en1 = en1;       assign if_b.en1 = en1;
  assign if_a.we0 = we0;       assign if_b.we0 = we0;
  assign if_a.we1 = we1;       assign if_b.we1 = we1;
  assign if_a.addr0 = addr0;   assign if_b.addr0 = addr0;
  assign if_a.addr1 = addr1;   assign if_b.addr1 = addr1;
  assign if_a.wdata0 = wdata0; assign if_b.wdata0 = wdata0;
  assign if_a.wdata1 = wdata1; assign if_b.wdata1 = wdata1;

  ram_block_tdp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(8), .READ_LATENCY(1),
                  .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)) dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
  ram_block_tdp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(8), .READ_LATENCY(2),
                  .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)) dut_b (.clk(clk), .rstn(rstn), .bus(if_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit rdy_exp();
    return rstn && !(cyc >= busy_from && cyc < rdy_at);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_port(input int s, input logic v, input logic [DW-1:0] d);
    sb_t e;
    if (v === 1'b1) begin
      if (expq[s].size() == 0) begin
        total++; bad++;
        $display("FAIL rvalid stream %0d: got unexpected strobe, data %h, expected none (cycle %0d)", s, d, cyc);
      end else begin
        e = expq[s].pop_front();
        chk($sformatf("rdata stream %0d", s), d, e.data);
        chk($sformatf("rvalid cycle stream %0d", s), cyc, e.cyc);
      end
    end else if (v !== 1'b0) begin
      total++; bad++;
      $display("FAIL rvalid stream %0d: got %b expected 0/1 (cycle %0d)", s, v, cyc);
    end else if (expq[s].size() != 0 && expq[s][0].cyc <= cyc) begin
      total++; bad++;
      $display("FAIL rvalid stream %0d: got no strobe, expected data %h at cycle %0d", s, expq[s][0].data, expq[s][0].cyc);
      void'(expq[s].pop_front());
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, tracks ready/collision every cycle.
  always @(negedge clk) begin
    chk_port(0, if_a.rvalid0, if_a.rdata0);
    chk_port(1, if_a.rvalid1, if_a.rdata1);
    chk_port(2, if_b.rvalid0, if_b.rdata0);
    chk_port(3, if_b.rvalid1, if_b.rdata1);
    chk("ready lat1", {31'd0, if_a.ready}, {31'd0, rdy_exp()});
    chk("ready lat2", {31'd0, if_b.ready}, {31'd0, rdy_exp()});
    chk("collision lat1", {31'd0, if_a.collision}, {31'd0, col_exp & COL_EN});
    chk("collision lat2", {31'd0, if_b.collision}, {31'd0, col_exp & COL_EN});
  end

  function automatic req_t nop();
    return '0;
  endfunction
  function automatic req_t rd(input logic [AW-1:0] a);
    req_t r; r = '0; r.en = 1'b1; r.addr = a; return r;
  endfunction
  function automatic req_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] w);
    req_t r; r.en = 1'b1; r.addr = a; r.wd = d; r.we = w; return r;
  endfunction
  function automatic req_t rnd();
    req_t r;
    r.en   = ($urandom_range(0, 3) != 0);
    r.we   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
    r.addr = 4'($urandom);
    r.wd   = $urandom;
    return r;
  endfunction

  task automatic mdl_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] w);
    for (int i = 0; i < NL; i++) if (w[i]) mdl[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic mdl_fill(input logic [DW-1:0] v);
    for (int i = 0; i < DEPTH; i++) mdl[i] = v;
  endtask

  // One cycle of stimulus; the model commits after the edge it describes.
  task automatic drive(input req_t p0, input req_t p1, input bit clr);
    bit ok;
    logic [31:0] c;
    c = cyc;
    ok = rdy_exp();
    en0 = p0.en; we0 = p0.we; addr0 = p0.addr; wdata0 = p0.wd;
    en1 = p1.en; we1 = p1.we; addr1 = p1.addr; wdata1 = p1.wd;
    clear = clr;
    if (ok && p0.en) begin
      expq[0].push_back('{data: mdl[p0.addr], cyc: c + 1});
      expq[2].push_back('{data: mdl[p0.addr], cyc: c + 2});
    end
    if (ok && p1.en) begin
      expq[1].push_back('{data: mdl[p1.addr], cyc: c + 1});
      expq[3].push_back('{data: mdl[p1.addr], cyc: c + 2});
    end
    @(posedge clk);
    if (ok) begin
      if (p1.en) mdl_write(p1.addr, p1.wd, p1.we & ((p0.en && p0.addr == p1.addr) ? ~p0.we : 4'hF));
      if (p0.en) mdl_write(p0.addr, p0.wd, p0.we);
      if (p0.en && p1.en && p0.addr == p1.addr && (p0.we & p1.we) != 0) col_exp = 1'b1;
      if (clr) begin
        busy_from = c + 1;
        rdy_at    = c + 18;
        mdl_fill(CV);
        col_exp = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(nop(), nop(), 1'b0);
  endtask

  task automatic do_reset(input int hold);
    rstn = 1'b0;
    en0 = 1'b0; en1 = 1'b0; clear = 1'b0;
    for (int s = 0; s < 4; s++) expq[s].delete();
    col_exp = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    chk("reset rdata0 lat1", if_a.rdata0, '0);
    chk("reset rdata1 lat1", if_a.rdata1, '0);
    chk("reset rdata0 lat2", if_b.rdata0, '0);
    chk("reset rdata1 lat2", if_b.rdata1, '0);
    chk("reset rvalid", {28'd0, if_a.rvalid0, if_a.rvalid1, if_b.rvalid0, if_b.rvalid1}, '0);
    chk("reset ready", {30'd0, if_a.ready, if_b.ready}, '0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    busy_from = 0;
    rdy_at = cyc + 17;
    mdl_fill(CV);
  endtask

  task automatic wait_ready_count();
    int n;
    n = 0;
    while (if_a.ready !== 1'b1 && n < 40) begin
      idle(1);
      n++;
    end
    chk("cycles from release to ready", n, 17);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) drive(rd(4'(a)), rd(4'(DEPTH - 1 - a)), 1'b0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    wait_ready_count();
    read_all();

    // Lane-masked write over the cleared word, then read back.
    drive(wr(4'd5, 32'h11223344, 4'b0101), nop(), 1'b0);
    drive(rd(4'd5), rd(4'd5), 1'b0);
    idle(3);

    // Write/write to the same address: port 0 wins.
    drive(wr(4'd3, 32'hDEADBEEF, 4'hF), wr(4'd3, 32'h0, 4'hF), 1'b0);
    drive(rd(4'd3), rd(4'd3), 1'b0);
    idle(3);

    // Back-to-back reads on port 1 (latency checked per stream).
    drive(nop(), rd(4'd1), 1'b0);
    drive(nop(), rd(4'd2), 1'b0);
    idle(4);

    // Clear pulse in the middle of random traffic; ready returns 18 cycles after the pulse.
    for (int i = 0; i < 28; i++) drive(rnd(), rnd(), i == 10);
    read_all();

    // Long random run with occasional clears.
    for (int i = 0; i < 400; i++) drive(rnd(), rnd(), $urandom_range(0, 49) == 0);
    idle(20);

    // Fill with non-clear data, then abort a reset sweep at address 7.
    for (int a = 0; a < DEPTH; a++) drive(wr(4'(a), $urandom, 4'hF), nop(), 1'b0);
    idle(2);
    do_reset(2);
    idle(7);
    do_reset(2);
    wait_ready_count();
    read_all();

    idle(4);
    for (int s = 0; s < 4; s++) chk($sformatf("scoreboard drained stream %0d", s), expq[s].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
